serial_tx_arbiter: RTL
======================

Name: serial_tx_arbiter

Overview:
- Shares one serial output line among N byte requesters.
- Arbitrates round-robin, accepts one byte per frame over a valid/ready handshake, and serializes it as: start bit 0, 8 data bits LSB first, stop bit 1.
- Idle line level is 1. The framing is exactly what the team's serial receiver FSM expects, so the two blocks form the loopback path.

Parameters:
- N_REQ, 4, number of requesters (>=1)
- CLKS_PER_BIT, 1, clock cycles per serial bit (>=1)
- GAP_BITS, 0, extra idle bit-times (line=1) forced after each stop bit (>=0)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  N_REQ  per-requester byte available
- req_data  in  8*N_REQ  byte of requester i in bits [8i+7:8i]
- req_ready  out  N_REQ  one-hot accept; transfer when valid&ready
- tx  out  1  serial line, registered
- busy  out  1  high whenever state != IDLE
- grant_id  out  max(1,$clog2(N_REQ))  index of most recently granted requester, held until next grant
- frame_done  out  1  one-cycle pulse after a stop bit completes

Behaviour:
- Reset values: tx=1, busy=0, req_ready=0, frame_done=0, grant_id=0, rr_ptr=0, state IDLE.
- Reset mid-frame: frame abandoned, tx=1 from the next edge, no frame_done.
- States: IDLE, START, DATA, STOP, GAP.
- IDLE, arbitration:
  - If any req_valid, winner g = first valid index scanning from rr_ptr upward, wrapping.
  - req_ready[g]=1 that same cycle (combinational from state and req_valid, one-hot); all others 0.
  - In IDLE with no valid, req_ready=0.
  - Handshake cycle T: latch req_data[g] into the shift register; grant_id<=g; rr_ptr<=(g+1) mod N_REQ; next state START.
  - req_ready=0 in all states other than IDLE.
- Requester rule: valid may drop only after its handshake. Data must be stable while valid=1.
- Bit timing, with a bit counter 0..7 and a cycle counter 0..CLKS_PER_BIT-1:
  - START: tx=0 during cycles T+1 .. T+CLKS_PER_BIT.
  - DATA: bit k (LSB first) on tx for CLKS_PER_BIT cycles each, k=0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
- After STOP:
  - GAP_BITS=0: return to IDLE.
  - GAP_BITS>0: enter GAP, tx=1 for GAP_BITS*CLKS_PER_BIT cycles, then IDLE.
- frame_done: high for exactly one cycle, the first cycle after the last STOP cycle (the first GAP or IDLE cycle).
- Back-to-back: with GAP_BITS=0, the next handshake may occur in that same first IDLE cycle. The next start bit then directly follows the stop bit. No extra idle cycle is inserted.
- Reference latency (CLKS_PER_BIT=1, GAP_BITS=0):
  - handshake T; start T+1; data T+2..T+9; stop T+10
  - frame_done and IDLE at T+11
  - frame period 11 cycles
- N_REQ=1: arbiter degenerates to a pass-through. rr_ptr and grant_id stay 0.
- Counter widths: $clog2(CLKS_PER_BIT) and $clog2(GAP_BITS*CLKS_PER_BIT), each min 1 bit. No overflow allowed.

Decomposition:
- Package serial_pkg holds:
  - state enum (IDLE/START/DATA/STOP/GAP)
  - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1
  - DATA_BITS=8, FRAME_BITS=10
  - The receiver side shares the same package.
- One natural sub-module: rr_arbiter, parameterized by N_REQ.
  - Combinational first-valid-from-pointer pick, plus the registered pointer update on handshake.
  - Outputs one-hot grant and index.

Test Plan:
- Single frame: N_REQ=4, CLKS_PER_BIT=1, requester 2 sends 0xA5 at T.
  - Required: tx = 1 (T), then 0,1,0,1,0,0,1,0,1,1 over T+1..T+10.
  - Required: frame_done only at T+11; grant_id=2.
- Round-robin: all four valid continuously.
  - Grant order 0,1,2,3,0,1.
  - Handshakes exactly 11 cycles apart; tx never idles between frames.
- Pointer skip: rr_ptr=1 and only requesters 0 and 3 valid.
  - Grant 3 then 0.
  - req_ready always one-hot or zero; never asserted outside IDLE.
- Bit stretching: CLKS_PER_BIT=4, GAP_BITS=2, byte 0x0F.
  - Each bit held 4 cycles: start 0, data 1111 0000, stop 1.
  - frame_done at T+41; tx=1 and busy=1 through T+48; next handshake no earlier than T+49.
- Reset mid-frame: reset asserted during data bit 3 for 1 cycle.
  - tx=1, busy=0, frame_done never pulses, rr_ptr=0.
  - A pending requester 1 with requester 0 also valid is granted 0 first afterward.
- Loopback: drive tx into the team's serial receiver with random bytes from all requesters.
  - Receiver done count equals frame_done count.
  - Received bytes match the sent bytes in grant order.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive path: state encoding,
// line levels and frame geometry.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } serial_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Counter/index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first valid requester at or above the pointer, wrapping,
// with the pointer moving past the winner on each accepted grant.
module rr_arbiter
    import serial_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = idx_width(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick;
    logic             found;

    // Upper pass covers indices at or above the pointer; the lower pass
    // only wins when nothing above it was valid, which gives the wrap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i] && (IDX_W'(i) >= rr_ptr)) begin
                found = 1'b1;
                pick  = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found = 1'b1;
                pick  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = enable && found && (pick == IDX_W'(i));
        end
    end

    assign grant_idx   = pick;
    assign grant_valid = enable && found;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (enable && found) begin
            rr_ptr <= (pick == IDX_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Shares one serial line among N_REQ byte sources: round-robin handshake in
// IDLE, then start bit, 8 data bits LSB first, stop bit and optional gap.
module serial_tx_arbiter
    import serial_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_BITS     = 0,
    localparam int IDX_W = idx_width(N_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [DATA_BITS*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [IDX_W-1:0]           grant_id,
    output logic                       frame_done
);

    localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
    localparam int CYC_W      = idx_width(CLKS_PER_BIT);
    localparam int GAP_W      = idx_width(GAP_CYCLES);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    serial_state_t          state;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   sel_byte;
    logic [2:0]             bit_cnt;
    logic [CYC_W-1:0]       cyc_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_valid;
    logic                   idle_state;
    logic                   handshake;

    assign idle_state = (state == IDLE);
    assign handshake  = idle_state && grant_valid;
    assign busy       = !idle_state;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .enable     (idle_state),
        .req_valid  (req_valid),
        .grant      (req_ready),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                sel_byte = req_data[DATA_BITS*i +: DATA_BITS];
            end
        end
    end

    // tx is registered: each transition loads the level of the bit that the
    // next state is about to drive, so the line changes exactly on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= IDLE_LEVEL;
            frame_done <= 1'b0;
            grant_id   <= '0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            cyc_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= IDLE_LEVEL;
                    if (handshake) begin
                        shift_reg <= sel_byte;
                        grant_id  <= grant_idx;
                        cyc_cnt   <= '0;
                        tx        <= START_BIT;
                        state     <= START;
                    end
                end
                START: begin
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        tx      <= shift_reg[0];
                        state   <= DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            tx    <= STOP_BIT;
                            state <= STOP;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_cnt    <= '0;
                        frame_done <= 1'b1;
                        tx         <= IDLE_LEVEL;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                GAP: begin
                    tx <= IDLE_LEVEL;
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= IDLE_LEVEL;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
